// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch stage: owns the PC, reads instruction memory, and holds the fetched word in IR for the decoder.
// Latency: a word accepted in cycle N (mem_req & mem_ready) shows up as ir/opcode/ir_valid and pc+1 in cycle N+1.
// Backpressure: memory stalls via mem_ready (unbounded); downstream stalls by withholding ir_ack while ir_valid=1.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   fetch enable; when low the unit parks in IDLE once the held instruction is acked
//   mem_req, mem_addr     instruction read request; mem_addr always mirrors pc
//   mem_ready, mem_rdata  read completion and instruction word
//   ir, opcode, ir_valid  instruction register, ir[15:12], and its unconsumed flag
//   ir_ack                downstream consume strobe
//   pc                    address of the next fetch
//   ld_pc, pc_target      redirect strobe and its target address
module lc3_fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic        ir_valid,
  input  logic        ir_ack,
  output logic [15:0] pc,
  input  logic        ld_pc,
  input  logic [15:0] pc_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_q, pc_nxt;
  logic [15:0] ir_q, ir_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= PC_RESET;
      ir_q  <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_q  <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;

    if (ld_pc) begin
      // A redirect beats everything: any word returning this cycle is
      // dropped, an ack in the same cycle is simply absorbed, and IR keeps
      // its stale contents (ir_valid falls because we leave VALID).
      pc_nxt    = pc_target;
      state_nxt = run ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) state_nxt = FETCH;
        end
        FETCH: begin
          // run is not consulted here: an issued request always completes.
          if (mem_ready) begin
            ir_nxt    = mem_rdata;
            pc_nxt    = pc_q + 16'h0001;  // 16-bit wrap, no carry out
            state_nxt = VALID;
          end
        end
        VALID: begin
          if (ir_ack) state_nxt = run ? FETCH : IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Moore outputs: purely from state and registers, so no input-to-output path.
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc_q;
  assign ir_valid = (state == VALID);
  assign ir       = ir_q;
  assign opcode   = ir_q[15:12];
  assign pc       = pc_q;

endmodule
